// File: rtl/clap_light_controller.sv
// Clap-command sequencer: decodes a clap-count token into toggle/dim, ramps the
// PWM brightness one level per RAMP_CYCLES, then locks out new commands for HOLDOFF_CYCLES.
module clap_light_controller #(
  parameter int SUC_CLAPS_WIDTH = 16,
  parameter int TOGGLE_CLAPS    = 2,
  parameter int DIM_CLAPS       = 3,
  parameter int LEVEL_WIDTH     = 3,
  parameter int RAMP_CYCLES     = 1024,
  parameter int HOLDOFF_CYCLES  = 65536
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
  input  logic                       suc_claps_valid,
  output logic                       suc_claps_ready,
  output logic                       detector_enable,
  output logic                       light_on,
  output logic [LEVEL_WIDTH-1:0]     level,
  output logic                       light
);

  localparam int MAX  = (1 << LEVEL_WIDTH) - 1;
  localparam int TMAX = (RAMP_CYCLES > HOLDOFF_CYCLES) ? RAMP_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]              RAMP_LAST = TW'(RAMP_CYCLES - 1);
  localparam logic [TW-1:0]              HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0]              T_ONE     = TW'(1);
  localparam logic [LEVEL_WIDTH-1:0]     LMAX      = LEVEL_WIDTH'(MAX);
  localparam logic [LEVEL_WIDTH-1:0]     L_ONE     = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0]     PWM_LAST  = LEVEL_WIDTH'(MAX - 1);
  localparam logic [SUC_CLAPS_WIDTH-1:0] TOG       = SUC_CLAPS_WIDTH'(TOGGLE_CLAPS);
  localparam logic [SUC_CLAPS_WIDTH-1:0] DIM       = SUC_CLAPS_WIDTH'(DIM_CLAPS);

  typedef enum logic [1:0] {IDLE, DECODE, RAMP, HOLDOFF} state_t;

  state_t                     state;
  logic [SUC_CLAPS_WIDTH-1:0] cnt;
  logic [LEVEL_WIDTH-1:0]     set_level;
  logic [LEVEL_WIDTH-1:0]     target;
  logic [TW-1:0]              timer;
  logic [LEVEL_WIDTH-1:0]     pwm_cnt;

  // Dimming cycles 1..MAX; a remembered brightness of 0 would make "on" look dark.
  function automatic logic [LEVEL_WIDTH-1:0] dim_step(input logic [LEVEL_WIDTH-1:0] cur);
    return (cur == LMAX) ? L_ONE : cur + L_ONE;
  endfunction

  assign suc_claps_ready = (state == IDLE);
  assign detector_enable = (state == IDLE) || (state == DECODE);

  always_ff @(posedge clock) begin
    if (state == IDLE && suc_claps_valid) cnt <= suc_claps_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      light_on  <= 1'b0;
      set_level <= LMAX;
      target    <= '0;
      level     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: if (suc_claps_valid) state <= DECODE;
        DECODE: begin
          if (cnt == TOG) begin
            light_on <= !light_on;
            target   <= light_on ? '0 : set_level;
            state    <= RAMP;
          end else if (cnt == DIM && light_on) begin
            set_level <= dim_step(set_level);
            target    <= dim_step(set_level);
            state     <= RAMP;
          end else begin
            state <= IDLE;
          end
        end
        RAMP: begin
          if (level == target) begin
            timer <= '0;
            state <= HOLDOFF;
          end else if (timer == RAMP_LAST) begin
            timer <= '0;
            level <= (level < target) ? level + L_ONE : level - L_ONE;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        HOLDOFF: begin
          if (timer == HOLD_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // PWM: period MAX so that level MAX is solid on and level 0 solid off.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt <= '0;
      light   <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt >= PWM_LAST) ? '0 : pwm_cnt + L_ONE;
      light   <= (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_clap_light_controller.sv
// Bench for clap_light_controller: table of clap tokens with expected light state,
// brightness and accept-to-ready latency, checked through a scoreboard queue.
module tb_clap_light_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] suc_claps_data;
  logic        suc_claps_valid;
  logic        suc_claps_ready;
  logic        detector_enable;
  logic        light_on;
  logic [2:0]  level;
  logic        light;

  int tests  = 0;
  int failed = 0;
  int prev_on  = 0;
  int prev_lvl = 0;

  typedef struct {int tok; bit hold; int on; int lvl; int lat;} vec_t;
  typedef struct {int on; int lvl; int lat;} exp_t;

  vec_t vecs[10];
  exp_t sbq[$];

  clap_light_controller #(
    .SUC_CLAPS_WIDTH(16), .TOGGLE_CLAPS(2), .DIM_CLAPS(3),
    .LEVEL_WIDTH(3), .RAMP_CYCLES(4), .HOLDOFF_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .suc_claps_data(suc_claps_data), .suc_claps_valid(suc_claps_valid),
    .suc_claps_ready(suc_claps_ready), .detector_enable(detector_enable),
    .light_on(light_on), .level(level), .light(light)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected brightness l cycles after the accept edge: steps land at l = 2 + 4n.
  function automatic int traj(input int l, input int from, input int to);
    int steps, n;
    steps = (to > from) ? to - from : from - to;
    n = (l < 2) ? 0 : (l - 2) / 4;
    if (n > steps) n = steps;
    return (to >= from) ? from + n : from - n;
  endfunction

  // Called at a negedge; returns at the negedge where ready has come back.
  task automatic run_vec(input int i, input int next_tok);
    exp_t e;
    int n, l, bad;
    e.on = vecs[i].on; e.lvl = vecs[i].lvl; e.lat = vecs[i].lat;
    sbq.push_back(e);
    suc_claps_data  = 16'(vecs[i].tok);
    suc_claps_valid = 1'b1;
    n = 0;
    while (!suc_claps_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!suc_claps_ready) begin
      check($sformatf("accept_timeout[%0d]", i), 0, 1);
      suc_claps_valid = 1'b0;
      void'(sbq.pop_front());
      return;
    end
    @(posedge clock);
    #1;
    if (vecs[i].hold) suc_claps_data = 16'(next_tok);
    else suc_claps_valid = 1'b0;
    l = 0;
    bad = 0;
    do begin
      @(negedge clock);
      l++;
      if (int'(level) != traj(l, prev_lvl, e.lvl)) bad++;
      if (int'(light_on) != ((l >= 2) ? e.on : prev_on)) bad++;
      if (!suc_claps_ready && (detector_enable != (l == 1))) bad++;
    end while (!suc_claps_ready && l < 200);
    e = sbq.pop_front();
    check($sformatf("latency[%0d]", i), l, e.lat);
    check($sformatf("light_on[%0d]", i), int'(light_on), e.on);
    check($sformatf("level[%0d]", i), int'(level), e.lvl);
    check($sformatf("trajectory_errs[%0d]", i), bad, 0);
    check($sformatf("det_en_at_ready[%0d]", i), int'(detector_enable), 1);
    prev_on  = e.on;
    prev_lvl = e.lvl;
  endtask

  task automatic count_light(input string name, input int cycles, input int exp);
    int hi;
    hi = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (light) hi++;
    end
    check(name, hi, exp);
  endtask

  initial begin
    int n;
    //          tok hold on lvl lat
    vecs[0] = '{2, 0, 1, 7, 39};
    vecs[1] = '{3, 0, 1, 1, 35};
    vecs[2] = '{2, 0, 0, 0, 15};
    vecs[3] = '{3, 0, 0, 0, 2};
    vecs[4] = '{0, 0, 0, 0, 2};
    vecs[5] = '{9, 0, 0, 0, 2};
    vecs[6] = '{2, 0, 1, 1, 15};
    vecs[7] = '{2, 1, 1, 7, 39};
    vecs[8] = '{3, 1, 1, 1, 35};
    vecs[9] = '{2, 0, 0, 0, 15};

    reset = 1'b1;
    suc_claps_valid = 1'b0;
    suc_claps_data = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", int'(suc_claps_ready), 1);
    check("rst_det_en", int'(detector_enable), 1);
    check("rst_light_on", int'(light_on), 0);
    check("rst_level", int'(level), 0);
    check("rst_light", int'(light), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, 0);
      if (i == 0) count_light("pwm_full_on", 14, 14);
      if (i == 1) count_light("pwm_level1", 14, 2);
    end

    // Clean restart, then reset while ramping up through level 4.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    prev_on = 0;
    prev_lvl = 0;
    suc_claps_data = 16'd2;
    suc_claps_valid = 1'b1;
    @(posedge clock);
    #1 suc_claps_valid = 1'b0;
    n = 0;
    while (level != 3'd4 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("midramp_level4", int'(level), 4);
    check("midramp_det_en", int'(detector_enable), 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_level", int'(level), 0);
    check("midrst_light", int'(light), 0);
    check("midrst_light_on", int'(light_on), 0);
    check("midrst_ready", int'(suc_claps_ready), 1);
    check("midrst_det_en", int'(detector_enable), 1);

    // Back-to-back tokens with valid held high through ramp and holdoff.
    for (int i = 7; i < 10; i++) run_vec(i, (i < 9) ? vecs[i + 1].tok : 0);
    repeat (5) @(negedge clock);
    check("no_extra_accept_level", int'(level), 0);
    check("no_extra_accept_ready", int'(suc_claps_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
